// File: rtl/jkff_bank_ctrl.sv
// Sequencer for a bank of external JK flip-flops. Each command step drives j/k for
// one cycle (DRIVE) and then releases them for one cycle (SETTLE). Count commands
// repeat this for cmd_cnt steps, recomputing j/k from q_fb before each step.
module jkff_bank_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [7:0]       cmd_cnt,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] OpNop       = 3'b000;
  localparam logic [2:0] OpClear     = 3'b001;
  localparam logic [2:0] OpSet       = 3'b010;
  localparam logic [2:0] OpToggle    = 3'b011;
  localparam logic [2:0] OpLoad      = 3'b100;
  localparam logic [2:0] OpCountUp   = 3'b101;
  localparam logic [2:0] OpCountDown = 3'b110;

  typedef enum logic [1:0] {StIdle, StDrive, StSettle} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       steps_q, steps_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic             done_q, done_d, err_q, err_d;

  // Bits that differ between q and q+/-1: toggling exactly those bits counts the bank.
  function automatic logic [WIDTH-1:0] step_mask(input logic [WIDTH-1:0] q, input logic down);
    logic [WIDTH-1:0] nxt;
    nxt = down ? q - 1'b1 : q + 1'b1;
    return q ^ nxt;
  endfunction

  // Next-state, j/k drive and completion pulses; j/k default to 0 outside DRIVE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    steps_d = steps_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (cmd_op)
            OpNop: done_d = 1'b1;
            OpClear, OpSet, OpToggle, OpLoad: begin
              op_d    = cmd_op;
              steps_d = 8'd1;
              state_d = StDrive;
              case (cmd_op)
                OpClear:  k_d = '1;
                OpSet:    j_d = '1;
                OpToggle: begin
                  j_d = cmd_data;
                  k_d = cmd_data;
                end
                default: begin
                  j_d = cmd_data;
                  k_d = ~cmd_data;
                end
              endcase
            end
            OpCountUp, OpCountDown: begin
              if (cmd_cnt != 8'd0) begin
                op_d    = cmd_op;
                steps_d = cmd_cnt;
                j_d     = step_mask(q_fb, cmd_op == OpCountDown);
                k_d     = j_d;
                state_d = StDrive;
              end else begin
                done_d = 1'b1;
              end
            end
            default: begin
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
        end
      end
      StDrive: state_d = StSettle;
      StSettle: begin
        if (steps_q > 8'd1) begin
          // Only count ops carry more than one step.
          steps_d = steps_q - 8'd1;
          j_d     = step_mask(q_fb, op_q == OpCountDown);
          k_d     = j_d;
          state_d = StDrive;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpNop;
      steps_q <= 8'd0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      steps_q <= steps_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jkff_bank_ctrl.sv
// Bench: a 4-bit JK flip-flop bank closes the loop; a command-level model predicts
// per-step j/k, the bank value after each step and the done/err timing.
module tb_jkff_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [7:0] cmd_cnt;
  logic [3:0] q_fb;
  logic [3:0] j;
  logic [3:0] k;
  logic       busy;
  logic       done;
  logic       err;

  logic       bank_load;
  logic [3:0] bank_val;
  logic [3:0] bank_q;
  logic [3:0] model_q;

  int checks = 0;
  int failures = 0;

  jkff_bank_ctrl #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_cnt  (cmd_cnt),
    .q_fb     (q_fb),
    .j        (j),
    .k        (k),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // External JK bank, with a preset path so the bench can choose a start value.
  always @(posedge clk) begin
    if (bank_load) bank_q <= bank_val;
    else           bank_q <= (j & ~bank_q) | (~k & bank_q);
  end
  assign q_fb = bank_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_bank(input logic [3:0] v);
    bank_load = 1'b1;
    bank_val  = v;
    @(posedge clk); #1;
    bank_load = 1'b0;
    model_q   = v;
    check_eq("bank_preset", bank_q, v);
  endtask

  // Random traffic on the command inputs while busy; the DUT must ignore it.
  task automatic noise();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op    = 3'($urandom);
    cmd_data  = 4'($urandom);
    cmd_cnt   = 8'($urandom);
  endtask

  // Issue one command from IDLE and follow it to completion; returns one cycle after done.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] data, input logic [7:0] cnt);
    int n;
    logic [3:0] nxt, ej, ek;
    if (op >= 3'd1 && op <= 3'd4) n = 1;
    else if (op == 3'd5 || op == 3'd6) n = int'(cnt);
    else n = 0;
    check_eq("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_cnt   = cnt;
    @(posedge clk); #1;
    if (n == 0) begin
      cmd_valid = 1'b0;
      check_eq("imm_done", done, 1);
      check_eq("imm_err", err, (op == 3'd7) ? 1 : 0);
      check_eq("imm_busy", busy, 0);
      check_eq("imm_jk", {j, k}, 0);
      return;
    end
    noise();
    for (int s = 0; s < n; s++) begin
      case (op)
        3'd1: begin ej = 4'h0; ek = 4'hF; nxt = 4'h0; end
        3'd2: begin ej = 4'hF; ek = 4'h0; nxt = 4'hF; end
        3'd3: begin ej = data; ek = data; nxt = model_q ^ data; end
        3'd4: begin ej = data; ek = ~data; nxt = data; end
        default: begin
          nxt = (op == 3'd6) ? model_q - 4'd1 : model_q + 4'd1;
          ej  = model_q ^ nxt;
          ek  = ej;
        end
      endcase
      check_eq("drive_busy", busy, 1);
      check_eq("drive_done", done, 0);
      check_eq("drive_j", j, ej);
      check_eq("drive_k", k, ek);
      @(posedge clk); #1;
      noise();
      check_eq("settle_jk", {j, k}, 0);
      check_eq("settle_busy", busy, 1);
      check_eq("settle_done", done, 0);
      check_eq("bank_q", bank_q, nxt);
      model_q = nxt;
      @(posedge clk); #1;
      if (s == n - 1) cmd_valid = 1'b0;
      else noise();
    end
    check_eq("end_done", done, 1);
    check_eq("end_err", err, 0);
    check_eq("end_busy", busy, 0);
    check_eq("end_jk", {j, k}, 0);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 4'd0;
    cmd_cnt   = 8'd0;
    bank_load = 1'b1;
    bank_val  = 4'd0;
    model_q   = 4'd0;
    #1;
    check_eq("rst_jk", {j, k}, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cmd_ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    bank_load = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("no_spurious_done", done, 0);
    end

    // Directed scenarios.
    set_bank(4'b0000);
    run_cmd(3'd4, 4'b1010, 8'd0);
    set_bank(4'b1110);
    run_cmd(3'd5, 4'd0, 8'd3);
    set_bank(4'b0000);
    run_cmd(3'd6, 4'd0, 8'd2);
    run_cmd(3'd1, 4'd0, 8'd0);
    run_cmd(3'd7, 4'hF, 8'd9);
    run_cmd(3'd0, 4'hF, 8'd9);
    run_cmd(3'd5, 4'hF, 8'd0);
    run_cmd(3'd2, 4'd0, 8'd0);

    // Reset during the second SETTLE of a COUNT_UP 5.
    set_bank(4'b0011);
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    cmd_cnt   = 8'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_eq("pre_rst_q", bank_q, 4'b0101);
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'd4;
    cmd_data  = 4'hF;
    #1;
    check_eq("abort_jk", {j, k}, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ready", cmd_ready, 1);
    @(posedge clk); #1;
    check_eq("rst_hs_ignored", {busy, done, j, k}, 0);
    check_eq("abort_q_kept", bank_q, 4'b0101);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_no_done", done, 0);
    model_q = 4'b0101;
    run_cmd(3'd3, 4'b0101, 8'd0);

    // Random back-to-back commands.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] c;
      if ($urandom_range(0, 7) == 0)       c = 8'd0;
      else if ($urandom_range(0, 15) == 0) c = 8'd17;
      else                                 c = 8'($urandom_range(1, 6));
      run_cmd(3'($urandom), 4'($urandom), c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jkff_bank_ctrl.md
JKFF_BANK_CTRL -- requirements
Module: jkff_bank_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: number of external JK flip-flops sequenced, one per bit.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  high exactly when state is IDLE, combinational from state.
REQ-006 cmd_op  input  3  opcode: 000 NOP, 001 CLEAR, 010 SET, 011 TOGGLE, 100 LOAD, 101 COUNT_UP, 110 COUNT_DOWN, 111 reserved.
REQ-007 cmd_data  input  WIDTH  TOGGLE mask or LOAD value.
REQ-008 cmd_cnt  input  8  step count for COUNT_UP/COUNT_DOWN, 0..255.
REQ-009 q_fb  input  WIDTH  q outputs of the flip-flop bank.
REQ-010 j  output  WIDTH  registered J drive to the bank.
REQ-011 k  output  WIDTH  registered K drive to the bank.
REQ-012 busy  output  1  high when state is not IDLE.
REQ-013 done  output  1  one-cycle completion pulse, registered.
REQ-014 err  output  1  one-cycle pulse, coincident with done, for a reserved opcode.

Function
REQ-015 States SHALL be IDLE, DRIVE and SETTLE; the handshake occurs at a posedge, E0, with cmd_valid=1 in IDLE.
REQ-016 Handshake with CLEAR/SET/TOGGLE/LOAD: latch op and data, load steps=1, go to DRIVE; j/k SHALL be set at E0 to CLEAR j=0,k=1s; SET j=1s,k=0; TOGGLE j=k=cmd_data; LOAD j=cmd_data,k=~cmd_data.
REQ-017 Handshake with COUNT_UP/COUNT_DOWN and cmd_cnt>0: latch op, load steps=cmd_cnt, go to DRIVE with j=k=q_fb^(q_fb+1) (up) or q_fb^(q_fb-1) (down), WIDTH-bit modular arithmetic.
REQ-018 DRIVE SHALL last exactly one cycle (bank captures at its closing edge); then go to SETTLE with j=k=0.
REQ-019 SETTLE SHALL last one cycle; if steps>1: decrement steps, recompute j/k from the current q_fb per REQ-017, go to DRIVE; else go to IDLE and set done=1.
REQ-020 Each step costs 2 cycles: done SHALL be set at edge E(2N), for N steps, and be visible in the cycle after it.
REQ-021 NOP, or COUNT with cmd_cnt=0: remain IDLE, set done=1 at E0, j/k stay 0, busy never asserts.
REQ-022 Reserved opcode 111: as REQ-021, plus err=1 at E0.
REQ-023 Wrap-around SHALL be natural: count up from all-ones drives j=k=all-ones (result 0); count down from 0 drives j=k=all-ones (result all-ones).
REQ-024 j and k SHALL be 0 in every IDLE and SETTLE cycle; no bit has j=k=1 except by TOGGLE/COUNT intent.
REQ-025 A new handshake in the same cycle that done is high SHALL be accepted normally.
REQ-026 cmd_valid outside IDLE SHALL be ignored; latched op/data/steps SHALL not change mid-operation.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, j=k=0, busy=0, done=0, err=0, steps=0, regardless of clock.
REQ-028 Reset mid-operation SHALL abort without a done pulse; handshakes SHALL be ignored while rst=1; first acceptance on the first posedge with rst=0.

Verification (WIDTH=4; the bench instantiates four JK flip-flops driven by j/k, feeding q_fb)
REQ-029 rst=1 -> j=k=0000, busy=0, cmd_ready=1, done=0, err=0; hold 2 cycles, release, verify no spurious done.
REQ-030 Bank q=0000, LOAD 1010 -> after E0 j=1010,k=0101; after E1 j=k=0, q=1010; done=1 after E2 only.
REQ-031 q=1110, COUNT_UP cnt=3 -> j/k step values 0001, 1111, 0001; q 1111, 0000, 0001; done after E6; busy high E0..E6.
REQ-032 q=0000, COUNT_DOWN cnt=2 -> q 1111 then 1110; done after E4; then CLEAR -> q=0000, done after E2.
REQ-033 COUNT_UP cnt=5, rst pulsed during second SETTLE -> j=k=0 immediately, busy=0, no done; q retains last value; next TOGGLE 0101 accepted and completes.
REQ-034 Opcode 111 -> done=err=1 for one cycle after E0, j/k never nonzero; NOP and COUNT cnt=0 -> done only, err=0.
